// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
//
// Multiplexed four-digit seven-segment scanner. A refresh prescaler divides
// the system clock into digit slots of PRESCALE cycles; at the end of every
// slot the digit register steps through the 2-bit successor (3 -> 0, else +1).
// A 16-bit hex value plus four decimal points is captured into a shadow
// register on load_i. The shadow is copied into the display register only at
// the frame boundary (last cycle of digit 3), so a frame never mixes old and
// new digits. The first BLANK cycles of every slot keep all anodes off so the
// previous digit's segments do not ghost onto the next anode.
//
// Ports
//   system1000       in   clock, rising-edge active
//   system1000_rstn  in   asynchronous active-low reset
//   value_i   [15:0] in   four hex digits, digit k = value_i[4k+3:4k]
//   dp_i      [3:0]  in   decimal point per digit, 1 = lit
//   load_i           in   capture value_i/dp_i into the shadow register
//   blank_i          in   force the display dark while high
//   seg_o     [6:0]  out  segments a..g (bit 0 = a), active-low, registered
//   dp_o             out  decimal point, active-low, registered
//   an_o      [3:0]  out  digit anodes, active-low, at most one low, registered
//   digit_o   [1:0]  out  current digit register
//   frame_o          out  one-cycle pulse at each frame start, registered
// -----------------------------------------------------------------------------
module sevenseg_scan #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    input  logic        blank_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic [1:0]  digit_o,
    output logic        frame_o
);

    localparam int PC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] prescaleCnt;
    logic [1:0]      digitReg;
    logic [15:0]     shadowValue;
    logic [3:0]      shadowDp;
    logic [15:0]     dispValue;
    logic [3:0]      dispDp;

    logic            slotWrap;
    logic            frameEdge;
    logic            inBlankWindow;
    logic            darkNow;
    logic [3:0]      curNibble;
    logic            curDp;

    // Active-high gfedcba glyph for one hex nibble.
    function automatic logic [6:0] decodeHex(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Digit-select successor: 3 wraps to 0, otherwise +1.
    function automatic logic [1:0] digitNext(input logic [1:0] cur);
        return (cur == 2'd3) ? 2'd0 : cur + 2'd1;
    endfunction

    assign slotWrap  = (prescaleCnt == PC_LAST);
    assign frameEdge = slotWrap && (digitReg == 2'd3);

    // With no blanking window the comparison would be constant-false, so it
    // is left out entirely rather than compared against zero.
    generate
        if (BLANK == 0) begin : gNoBlank
            assign inBlankWindow = 1'b0;
        end else begin : gBlank
            localparam logic [PC_W-1:0] BLANK_PC = PC_W'(BLANK);
            assign inBlankWindow = (prescaleCnt < BLANK_PC);
        end
    endgenerate

    assign darkNow = inBlankWindow || blank_i;

    always_comb begin
        curNibble = dispValue[3:0];
        curDp     = dispDp[0];
        case (digitReg)
            2'd0: begin
                curNibble = dispValue[3:0];
                curDp     = dispDp[0];
            end
            2'd1: begin
                curNibble = dispValue[7:4];
                curDp     = dispDp[1];
            end
            2'd2: begin
                curNibble = dispValue[11:8];
                curDp     = dispDp[2];
            end
            default: begin
                curNibble = dispValue[15:12];
                curDp     = dispDp[3];
            end
        endcase
    end

    // Refresh prescaler and digit register.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            prescaleCnt <= '0;
            digitReg    <= 2'd0;
        end else begin
            if (slotWrap) begin
                prescaleCnt <= '0;
                digitReg    <= digitNext(digitReg);
            end else begin
                prescaleCnt <= prescaleCnt + PC_W'(1);
            end
        end
    end

    // Shadow captures on any load; the display register only takes the
    // pre-edge shadow at the frame boundary, so a load on that same edge
    // appears one frame later.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            shadowValue <= '0;
            shadowDp    <= '0;
            dispValue   <= '0;
            dispDp      <= '0;
        end else begin
            if (load_i) begin
                shadowValue <= value_i;
                shadowDp    <= dp_i;
            end
            if (frameEdge) begin
                dispValue <= shadowValue;
                dispDp    <= shadowDp;
            end
        end
    end

    // Registered display drive, one cycle behind the scan state.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            an_o    <= 4'hF;
            frame_o <= 1'b0;
        end else begin
            frame_o <= frameEdge;
            if (darkNow) begin
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
                an_o  <= 4'hF;
            end else begin
                seg_o <= ~decodeHex(curNibble);
                dp_o  <= ~curDp;
                an_o  <= ~(4'b0001 << digitReg);
            end
        end
    end

    assign digit_o = digitReg;

endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;

    logic        clk;
    logic        rstn;
    logic [15:0] valueIn;
    logic [3:0]  dpIn;
    logic        loadIn;
    logic        blankIn;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit;
    logic        frame;

    int nAssert = 0;
    int nFail   = 0;
    int edgeNum = 0;

    sevenseg_scan #(.PRESCALE(4), .BLANK(1)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .value_i         (valueIn),
        .dp_i            (dpIn),
        .load_i          (loadIn),
        .blank_i         (blankIn),
        .seg_o           (seg),
        .dp_o            (dp),
        .an_o            (an),
        .digit_o         (digit),
        .frame_o         (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge n (counted from
    // the last reset release).
    task automatic gotoEdge(input int n);
        while (edgeNum < n) begin
            @(negedge clk);
            edgeNum++;
        end
    endtask

    task automatic chkDisp(input string tag, input logic [3:0] expAn,
                           input logic [6:0] expSeg, input logic expDp);
        chk({tag, "_an"}, {12'h0, an}, {12'h0, expAn});
        chk({tag, "_seg"}, {9'h0, seg}, {9'h0, expSeg});
        chk({tag, "_dp"}, {15'h0, dp}, {15'h0, expDp});
    endtask

    initial begin
        rstn    = 1'b0;
        valueIn = 16'h0;
        dpIn    = 4'h0;
        loadIn  = 1'b0;
        blankIn = 1'b0;
        repeat (3) @(negedge clk);

        chkDisp("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_digit", {14'h0, digit}, 16'h0);
        chk("reset_frame", {15'h0, frame}, 16'h0);

        rstn = 1'b1;
        edgeNum = 0;

        gotoEdge(1);
        chkDisp("first_blank", 4'hF, 7'h7F, 1'b1);
        chk("first_digit", {14'h0, digit}, 16'h0);
        loadIn  = 1'b1;
        valueIn = 16'h1234;
        dpIn    = 4'h0;

        gotoEdge(2);
        loadIn = 1'b0;
        chkDisp("zero_d0", 4'hE, 7'h40, 1'b1);

        gotoEdge(6);
        chkDisp("zero_d1", 4'hD, 7'h40, 1'b1);
        chk("digit_e6", {14'h0, digit}, 16'h1);

        gotoEdge(15);
        chk("frame_e15", {15'h0, frame}, 16'h0);
        gotoEdge(16);
        chk("frame_e16", {15'h0, frame}, 16'h1);
        chk("digit_e16", {14'h0, digit}, 16'h0);
        chkDisp("zero_d3", 4'h7, 7'h40, 1'b1);

        gotoEdge(17);
        chk("frame_e17", {15'h0, frame}, 16'h0);
        chkDisp("blank_e17", 4'hF, 7'h7F, 1'b1);
        gotoEdge(18);
        chkDisp("v1234_d0", 4'hE, 7'h19, 1'b1);
        gotoEdge(21);
        chkDisp("blank_e21", 4'hF, 7'h7F, 1'b1);
        gotoEdge(22);
        chkDisp("v1234_d1", 4'hD, 7'h30, 1'b1);

        gotoEdge(23);
        loadIn  = 1'b1;
        valueIn = 16'hABCD;
        gotoEdge(24);
        loadIn = 1'b0;

        gotoEdge(26);
        chkDisp("v1234_d2", 4'hB, 7'h24, 1'b1);
        gotoEdge(30);
        chkDisp("v1234_d3", 4'h7, 7'h79, 1'b1);
        gotoEdge(32);
        chk("frame_e32", {15'h0, frame}, 16'h1);
        gotoEdge(34);
        chkDisp("vABCD_d0", 4'hE, 7'h21, 1'b1);
        gotoEdge(46);
        chkDisp("vABCD_d3", 4'h7, 7'h08, 1'b1);

        gotoEdge(47);
        loadIn  = 1'b1;
        valueIn = 16'hFFFF;
        gotoEdge(48);
        loadIn = 1'b0;
        chk("frame_e48", {15'h0, frame}, 16'h1);
        gotoEdge(50);
        chkDisp("bnd_still_d0", 4'hE, 7'h21, 1'b1);
        gotoEdge(62);
        chkDisp("bnd_still_d3", 4'h7, 7'h08, 1'b1);
        gotoEdge(64);
        chk("frame_e64", {15'h0, frame}, 16'h1);
        gotoEdge(66);
        chkDisp("vFFFF_d0", 4'hE, 7'h0E, 1'b1);
        gotoEdge(70);
        chkDisp("vFFFF_d1", 4'hD, 7'h0E, 1'b1);
        gotoEdge(74);
        chkDisp("vFFFF_d2", 4'hB, 7'h0E, 1'b1);
        gotoEdge(78);
        chkDisp("vFFFF_d3", 4'h7, 7'h0E, 1'b1);

        gotoEdge(81);
        loadIn  = 1'b1;
        valueIn = 16'hFFFF;
        dpIn    = 4'b0100;
        gotoEdge(82);
        loadIn = 1'b0;
        dpIn   = 4'h0;

        gotoEdge(96);
        chk("frame_e96", {15'h0, frame}, 16'h1);
        gotoEdge(99);
        chkDisp("dp_d0_off", 4'hE, 7'h0E, 1'b1);

        gotoEdge(101);
        blankIn = 1'b1;
        gotoEdge(102);
        chkDisp("blank_e102", 4'hF, 7'h7F, 1'b1);
        gotoEdge(103);
        chk("blank_digit_e103", {14'h0, digit}, 16'h1);
        gotoEdge(104);
        chkDisp("blank_e104", 4'hF, 7'h7F, 1'b1);
        gotoEdge(105);
        chk("blank_digit_e105", {14'h0, digit}, 16'h2);
        gotoEdge(107);
        chkDisp("blank_e107", 4'hF, 7'h7F, 1'b1);
        blankIn = 1'b0;
        gotoEdge(108);
        chkDisp("dp_d2_on", 4'hB, 7'h0E, 1'b0);
        gotoEdge(110);
        chkDisp("dp_d3_off", 4'h7, 7'h0E, 1'b1);

        gotoEdge(122);
        chkDisp("pre_rst_d2", 4'hB, 7'h0E, 1'b0);
        rstn = 1'b0;
        #1;
        chkDisp("async_rst", 4'hF, 7'h7F, 1'b1);
        chk("async_rst_digit", {14'h0, digit}, 16'h0);
        chk("async_rst_frame", {15'h0, frame}, 16'h0);
        repeat (2) @(negedge clk);
        chkDisp("held_rst", 4'hF, 7'h7F, 1'b1);
        rstn = 1'b1;
        edgeNum = 0;

        gotoEdge(1);
        chkDisp("rst2_blank", 4'hF, 7'h7F, 1'b1);
        chk("rst2_digit_e1", {14'h0, digit}, 16'h0);
        gotoEdge(2);
        chkDisp("rst2_d0", 4'hE, 7'h40, 1'b1);
        gotoEdge(4);
        chk("rst2_digit_e4", {14'h0, digit}, 16'h1);
        gotoEdge(6);
        chkDisp("rst2_d1", 4'hD, 7'h40, 1'b1);
        gotoEdge(16);
        chk("rst2_frame_e16", {15'h0, frame}, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Multiplexed four-digit seven-segment scanner for the SevenSeg display path. Sits directly downstream of the 2-bit digit-select successor (3 wraps to 0, otherwise +1). It owns the digit register and a refresh prescaler, and drives that register through the successor once per slot. It latches a 16-bit hex value, decodes the selected nibble and drives active-low segment and anode lines with anti-ghosting blanking and tear-free frame updates.

## Interface
- PRESCALE, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLANK, 16: dead cycles at the start of each slot with anodes off; legal range 0 ≤ BLANK < PRESCALE.
- system1000  in  1  clock; all state changes on its rising edge.
- system1000_rstn  in  1  reset, asynchronous, active-low.
- value_i  in  16  four hex digits; digit k = value_i[4k+3:4k].
- dp_i  in  4  decimal point per digit; 1 = lit.
- load_i  in  1  capture value_i/dp_i into the shadow register.
- blank_i  in  1  force display dark while high.
- seg_o  out  7  segments, bit 0 = a … bit 6 = g; active-low.
- dp_o  out  1  decimal point; active-low.
- an_o  out  4  digit anodes; active-low, at most one low.
- digit_o  out  2  current digit register.
- frame_o  out  1  one-cycle pulse at each frame start.

## Operation
- State: prescaler pc (ceil(log2(PRESCALE)) bits), digit register d (2 bits), shadow register {sv, sdp}, display register {dv, ddp}, output registers seg_o/dp_o/an_o/frame_o.
- Prescaler:
  - pc counts 0..PRESCALE-1 and wraps to 0.
  - On the wrap edge, d advances: 3 → 0, otherwise d+1 (2-bit).
- Shadow: on any edge with load_i=1, sv ← value_i and sdp ← dp_i.
- Frame boundary is the edge where pc = PRESCALE-1 and d = 3. On that edge:
  - dv ← sv and ddp ← sdp, using pre-edge shadow contents.
  - load_i on the same edge updates the shadow only; the new value is displayed one frame later.
- Decode, active-high gfedcba patterns; seg_o is the bitwise inverse:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Dark condition: pc < BLANK, or blank_i = 1.
  - Dark: an_o ← 4'hF, seg_o ← 7'h7F, dp_o ← 1.
  - Otherwise: an_o ← ~(1 << d), seg_o ← ~decode(dv[4d+3:4d]), dp_o ← ~ddp[d].
- digit_o = d, combinational from the register.
- frame_o ← 1 on the frame-boundary edge, else 0.
- Reset values, asynchronous, all held while system1000_rstn=0:
  - pc=0, d=0, sv=dv=0, sdp=ddp=0
  - seg_o=7'h7F, dp_o=1, an_o=4'hF, digit_o=0, frame_o=0
- After reset release, the first frame displays 0000 with decimal points off until the first boundary copies the shadow.

## Timing
- seg_o, dp_o and an_o are registered: they reflect pc/d/dv/blank_i sampled on the previous edge (1-cycle latency).
- Slot length is exactly PRESCALE cycles; frame length is 4·PRESCALE cycles.
- frame_o is high for one cycle, concurrent with d=0 and pc=0 of the new frame. Consecutive pulses are 4·PRESCALE cycles apart.
- blank_i takes effect on outputs one cycle after it is sampled. It does not stall pc or d.
- load_i needs no handshake. It is a single-cycle capture; the last load before a boundary wins.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronously). Scanning restarts at digit 0, pc=0, on the first edge after release.
- With BLANK=0 an anode is never dark except via blank_i.

## Test plan
- Reset (PRESCALE=4, BLANK=1), release, no load → an_o=F for one cycle, then digit 0 shows seg_o=40 (glyph "0"). frame_o first pulses 16 cycles after release.
- Load value_i=16'h1234, dp_i=0 one cycle after reset release, then run one frame → after the next frame_o, per slot: blanked cycle, then
  - an_o=E / seg_o=19
  - an_o=D / seg_o=30
  - an_o=B / seg_o=24
  - an_o=7 / seg_o=79
- Tear-free update: while showing 1234, load 16'hABCD mid-frame → remaining slots still show 1234. After frame_o, digit 0 shows seg_o=21 (d) and digit 3 shows seg_o=08 (A).
- Boundary load: load_i=1 with value_i=16'hFFFF on the frame-boundary edge → the following frame still shows the previous shadow. The frame after that shows seg_o=0E on every digit.
- Blank and dp: dp_i=4'b0100 loaded; blank_i high for 6 cycles mid-frame → an_o=F and seg_o=7F from the cycle after blank_i rises until one cycle after it falls. digit_o keeps advancing. dp_o=0 only during digit-2 unblanked cycles.
- Reset mid-operation: assert system1000_rstn=0 during digit 2 → same cycle an_o=F, seg_o=7F, digit_o=0. After release, d and the prescaler restart from 0 and the display reverts to 0000.
